ct_wrr_sched: RTL and testbench
===============================

Name: ct_wrr_sched

Overview:
- Weighted round-robin, packet-atomic grant controller that owns the input-select of an NI-way merge datapath.
- Decides which requester holds the shared output channel. Holds the grant until end-of-packet, and allows up to a configurable number of back-to-back packets per grant.
- Watches the channel's output handshake to learn packet boundaries.
- Sits beside the merge mux and drives its select. Replaces the merge's built-in fixed-weight arbitration where bandwidth shaping is required.

Parameters:
- NI, 4, number of requesters (2..16).
- WBITS, 4, width of each per-input weight field.
- NIBITS, localparam = CLogB2(NI-1), width of the grant index.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_req  in  NI  per-input request: a packet is pending or in flight
- i_weight  in  NI*WBITS  packed per-input packet quota; field i at [WBITS*i +: WBITS]; 0 treated as 1
- i_xfer  in  1  beat accepted on the shared output (valid && ready)
- i_xfer_eop  in  1  accepted beat is the last of its packet; qualified by i_xfer
- o_grant_idx  out  NIBITS  input currently selected onto the output
- o_grant_valid  out  1  a grant is held (state LOCKED)
- o_burst_cnt  out  WBITS  packets completed so far in the current grant
- o_err  out  1  sticky: i_xfer seen while no grant held

Behaviour:
- Reset (asynchronous, active-high, clk domain): state IDLE; o_grant_idx=0; o_grant_valid=0; o_burst_cnt=0; o_err=0; RR pointer last=NI-1, so input 0 has first priority.
- All outputs are registered. No combinational path from any input to any output.
- RR pick: the first requester scanning last+1, last+2, ... wrapping modulo NI, with last checked last. The current holder therefore wins only if no other input requests.
- IDLE:
  - If |i_req, next cycle: LOCKED, o_grant_idx=pick, o_grant_valid=1, o_burst_cnt=0, quota latched = max(1, i_weight[pick]).
  - Grant latency is 1 cycle from i_req rising.
  - Otherwise stay in IDLE; o_grant_idx holds its old value.
- LOCKED, no i_xfer, or i_xfer without i_xfer_eop: hold everything. Requester deassertion mid-packet does NOT drop the grant; the grant is packet-atomic.
- LOCKED, i_xfer && i_xfer_eop. Let n = o_burst_cnt+1.
  - n < quota and i_req[grant] this cycle: stay on the same input; o_burst_cnt=n.
  - Else if |i_req: regrant to pick with last=grant. Zero-bubble: the new grant is visible the cycle after eop. o_burst_cnt=0; quota re-latched from i_weight of the new input.
  - Else: go to IDLE; o_grant_valid=0; last=grant.
- Weights are sampled only at grant start. Changes mid-burst take effect at the next grant.
- o_burst_cnt arithmetic: WBITS wide. It never wraps, because it is bounded by quota-1 ≤ 2^WBITS-2.
- Single requester: after its quota expires it is regranted immediately (pick returns itself). The cycle is LOCKED→LOCKED with o_burst_cnt reset to 0.
- i_xfer in IDLE: ignored for state; o_err set and held until reset.
- Simultaneous eop and request changes: i_req values sampled in the eop cycle decide the next grant.
- Reset mid-packet: the grant is dropped immediately (async). The datapath is reset by the same signal.

Decomposition:
- Package ct_sched_pkg holds:
  - a state enum {IDLE, LOCKED};
  - the CLogB2 function;
  - a weight-normalise function, max(1, w).
- One combinational sub-module, ct_rr_pick. Inputs: req[NI], last[NIBITS]. Outputs: idx[NIBITS], any. Implemented as a rotate plus priority encoder.
- ct_wrr_sched contains the FSM, counters and registers.

Test Plan:
- Reset, then i_req=4'b0101 → one cycle later o_grant_valid=1, o_grant_idx=0; 3-beat packet with eop → next cycle o_grant_idx=2, zero bubble.
- Weights {1,1,1,3}, all requesting, each packet 1 beat → grant sequence 0,1,2,3,3,3,0,... with o_burst_cnt 0,0,0,0,1,2,0.
- Input 1 alone, weight 2, continuous 1-beat packets → o_grant_idx stays 1 and o_grant_valid stays 1 throughout; o_burst_cnt toggles 0,1,0,1.
- Grant held on input 2, i_req[2] drops mid-packet → grant held until i_xfer_eop; then with no requests → IDLE, o_grant_valid=0, o_grant_idx=2.
- i_xfer=1 in IDLE → o_err=1 next cycle and it stays set. Weight 0 on input 0 → behaves as quota 1.
- Assert reset asynchronously mid-burst (between clock edges) → all outputs are at reset values before the next clk edge. After release, the first grant goes to the lowest-index requester.

Source files
------------

// File: rtl/ct_sched_pkg.sv
// Shared types and helpers for the weighted round-robin grant controller.
// Holds the FSM state enum, index-width function and weight normalisation.
package ct_sched_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Bits needed to hold val (at least 1).
    function automatic int CLogB2(input int val);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((val >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

    // A zero weight still allows one packet per grant.
    function automatic int unsigned norm_w(input int unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/ct_rr_pick.sv
// Round-robin picker: first requester after 'last', wrapping, last checked last.
// Rotates the request vector so the search starts at last+1, then priority-encodes.
module ct_rr_pick
    import ct_sched_pkg::*;
#(
    parameter int NI     = 4,
    parameter int NIBITS = CLogB2(NI - 1)
) (
    input  logic [NI-1:0]     i_req,
    input  logic [NIBITS-1:0] i_last,
    output logic [NIBITS-1:0] o_idx,
    output logic              o_any
);

    logic [NI-1:0] w_rot;
    int unsigned   w_start;
    int unsigned   w_off;
    int unsigned   w_sum;

    // Rotate, find lowest set bit, map the offset back to an input index.
    always_comb begin
        w_start = 32'(i_last) + 32'd1;
        w_rot   = NI'({i_req, i_req} >> w_start);
        w_off   = 32'd0;
        for (int k = NI - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = 32'(k);
        end
        w_sum = w_start + w_off;
        if (w_sum >= 32'(NI)) w_sum = w_sum - 32'(NI);
        o_idx = NIBITS'(w_sum);
        o_any = |i_req;
    end

endmodule

// File: rtl/ct_wrr_sched.sv
// Packet-atomic weighted round-robin grant controller for an NI-way merge.
// Grant is held to end-of-packet; up to 'weight' packets per grant.
module ct_wrr_sched
    import ct_sched_pkg::*;
#(
    parameter  int NI     = 4,
    parameter  int WBITS  = 4,
    localparam int NIBITS = CLogB2(NI - 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NI-1:0]       i_req,
    input  logic [NI*WBITS-1:0] i_weight,
    input  logic                i_xfer,
    input  logic                i_xfer_eop,
    output logic [NIBITS-1:0]   o_grant_idx,
    output logic                o_grant_valid,
    output logic [WBITS-1:0]    o_burst_cnt,
    output logic                o_err
);

    state_t              r_state;
    logic [NIBITS-1:0]   r_grant;
    logic [NIBITS-1:0]   r_last;
    logic                r_valid;
    logic [WBITS-1:0]    r_cnt;
    logic [WBITS-1:0]    r_quota;
    logic                r_err;

    logic [NIBITS-1:0]   w_last;
    logic [NIBITS-1:0]   w_idx;
    logic                w_any;
    logic [WBITS-1:0]    w_wraw;
    logic [WBITS-1:0]    w_quota;
    logic [WBITS-1:0]    w_next;

    // While locked the holder is the RR reference; otherwise the last holder.
    always_comb begin
        w_last  = (r_state == LOCKED) ? r_grant : r_last;
        w_wraw  = i_weight[WBITS*w_idx +: WBITS];
        w_quota = WBITS'(norm_w(32'(w_wraw)));
        w_next  = r_cnt + WBITS'(1);
    end

    ct_rr_pick #(
        .NI     (NI),
        .NIBITS (NIBITS)
    ) u_pick (
        .i_req  (i_req),
        .i_last (w_last),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    // Grant FSM: latch pick on idle request, advance only on end-of-packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= NIBITS'(NI - 1);
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_quota <= WBITS'(1);
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_xfer) r_err <= 1'b1;
                    if (w_any) begin
                        r_state <= LOCKED;
                        r_valid <= 1'b1;
                        r_grant <= w_idx;
                        r_cnt   <= '0;
                        r_quota <= w_quota;
                    end
                end
                LOCKED: begin
                    if (i_xfer && i_xfer_eop) begin
                        if ((w_next < r_quota) && i_req[r_grant]) begin
                            r_cnt <= w_next;
                        end else if (w_any) begin
                            r_last  <= r_grant;
                            r_grant <= w_idx;
                            r_cnt   <= '0;
                            r_quota <= w_quota;
                        end else begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                            r_last  <= r_grant;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_grant_idx   = r_grant;
    assign o_grant_valid = r_valid;
    assign o_burst_cnt   = r_cnt;
    assign o_err         = r_err;

endmodule

// File: tb/tb_ct_wrr_sched.sv
// Bench for ct_wrr_sched: directed scenarios plus random traffic
// checked against an abstract grant model.
module tb_ct_wrr_sched;

    localparam int NI    = 4;
    localparam int WBITS = 4;
    localparam int NIB   = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [NI-1:0]       req;
    logic [NI*WBITS-1:0] wt;
    logic                xfer;
    logic                eop;
    logic [NIB-1:0]      gidx;
    logic                gval;
    logic [WBITS-1:0]    bcnt;
    logic                err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ct_wrr_sched #(
        .NI    (NI),
        .WBITS (WBITS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req         (req),
        .i_weight      (wt),
        .i_xfer        (xfer),
        .i_xfer_eop    (eop),
        .o_grant_idx   (gidx),
        .o_grant_valid (gval),
        .o_burst_cnt   (bcnt),
        .o_err         (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req   = '0;
        wt    = {4'd1, 4'd1, 4'd1, 4'd1};
        xfer  = 1'b0;
        eop   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic int mpick(input logic [NI-1:0] r, input int last);
        for (int k = 1; k <= NI; k++) begin
            int j;
            j = (last + k) % NI;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        req   = 4'b1111;
        xfer  = 1'b1;
        eop   = 1'b1;
        tick();
        total++;
        if ({gval, gidx, bcnt, err} !== 8'd0) begin
            bad++;
            $display("FAIL reset_state got=%b exp=%b", {gval, gidx, bcnt, err}, 8'd0);
        end
        do_reset();
    endtask

    task automatic test_zero_bubble;
        do_reset();
        req = 4'b0101;
        tick();
        total++;
        if ({gval, gidx, bcnt} !== {1'b1, 2'd0, 4'd0}) begin
            bad++;
            $display("FAIL zb_first got=%b/%0d/%0d exp=1/0/0", gval, gidx, bcnt);
        end
        xfer = 1'b1;
        for (int b = 0; b < 2; b++) begin
            tick();
            total++;
            if ({gval, gidx} !== {1'b1, 2'd0}) begin
                bad++;
                $display("FAIL zb_hold beat=%0d got=%b/%0d exp=1/0", b, gval, gidx);
            end
        end
        eop = 1'b1;
        tick();
        total++;
        if ({gval, gidx, bcnt} !== {1'b1, 2'd2, 4'd0}) begin
            bad++;
            $display("FAIL zb_regrant got=%b/%0d/%0d exp=1/2/0", gval, gidx, bcnt);
        end
        xfer = 1'b0;
        eop  = 1'b0;
    endtask

    task automatic test_weighted_seq;
        int exp_idx [6] = '{1, 2, 3, 3, 3, 0};
        int exp_cnt [6] = '{0, 0, 0, 1, 2, 0};
        do_reset();
        wt  = {4'd3, 4'd1, 4'd1, 4'd1};
        req = 4'b1111;
        tick();
        total++;
        if ({gval, gidx, bcnt} !== {1'b1, 2'd0, 4'd0}) begin
            bad++;
            $display("FAIL wseq_first got=%b/%0d/%0d exp=1/0/0", gval, gidx, bcnt);
        end
        xfer = 1'b1;
        eop  = 1'b1;
        for (int s = 0; s < 6; s++) begin
            tick();
            total++;
            if (gidx !== NIB'(exp_idx[s]) || bcnt !== WBITS'(exp_cnt[s]) || gval !== 1'b1) begin
                bad++;
                $display("FAIL wseq step=%0d got=%0d/%0d exp=%0d/%0d", s, gidx, bcnt, exp_idx[s], exp_cnt[s]);
            end
        end
        xfer = 1'b0;
        eop  = 1'b0;
    endtask

    task automatic test_single_requester;
        do_reset();
        wt  = {4'd1, 4'd1, 4'd2, 4'd1};
        req = 4'b0010;
        tick();
        xfer = 1'b1;
        eop  = 1'b1;
        for (int s = 0; s < 6; s++) begin
            tick();
            total++;
            if ({gval, gidx, bcnt} !== {1'b1, 2'd1, WBITS'((s + 1) % 2)}) begin
                bad++;
                $display("FAIL single step=%0d got=%b/%0d/%0d exp=1/1/%0d", s, gval, gidx, bcnt, (s + 1) % 2);
            end
        end
        xfer = 1'b0;
        eop  = 1'b0;
    endtask

    task automatic test_mid_packet_drop;
        do_reset();
        req = 4'b0100;
        tick();
        xfer = 1'b1;
        tick();
        req = 4'b0000;
        tick();
        xfer = 1'b0;
        tick();
        total++;
        if ({gval, gidx} !== {1'b1, 2'd2}) begin
            bad++;
            $display("FAIL drop_hold got=%b/%0d exp=1/2", gval, gidx);
        end
        xfer = 1'b1;
        eop  = 1'b1;
        tick();
        xfer = 1'b0;
        eop  = 1'b0;
        total++;
        if ({gval, gidx, err} !== {1'b0, 2'd2, 1'b0}) begin
            bad++;
            $display("FAIL drop_idle got=%b/%0d/%b exp=0/2/0", gval, gidx, err);
        end
        tick();
        total++;
        if ({gval, gidx} !== {1'b0, 2'd2}) begin
            bad++;
            $display("FAIL drop_idle2 got=%b/%0d exp=0/2", gval, gidx);
        end
    endtask

    task automatic test_err_w0;
        do_reset();
        xfer = 1'b1;
        tick();
        xfer = 1'b0;
        total++;
        if ({err, gval} !== 2'b10) begin
            bad++;
            $display("FAIL err_set got=%b/%b exp=1/0", err, gval);
        end
        tick();
        tick();
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky got=%b exp=1", err);
        end
        wt  = {4'd1, 4'd1, 4'd1, 4'd0};
        req = 4'b0001;
        tick();
        xfer = 1'b1;
        eop  = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            total++;
            if ({gval, gidx, bcnt, err} !== {1'b1, 2'd0, 4'd0, 1'b1}) begin
                bad++;
                $display("FAIL w0 step=%0d got=%b/%0d/%0d/%b exp=1/0/0/1", s, gval, gidx, bcnt, err);
            end
        end
        xfer = 1'b0;
        eop  = 1'b0;
    endtask

    task automatic test_async_reset;
        do_reset();
        wt  = {4'd1, 4'd1, 4'd1, 4'd3};
        req = 4'b0001;
        tick();
        xfer = 1'b1;
        eop  = 1'b1;
        tick();
        xfer = 1'b0;
        eop  = 1'b0;
        total++;
        if ({gval, gidx, bcnt} !== {1'b1, 2'd0, 4'd1}) begin
            bad++;
            $display("FAIL ar_pre got=%b/%0d/%0d exp=1/0/1", gval, gidx, bcnt);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({gval, gidx, bcnt, err} !== 8'd0) begin
            bad++;
            $display("FAIL ar_async got=%b exp=%b", {gval, gidx, bcnt, err}, 8'd0);
        end
        req = 4'b1010;
        #1;
        reset = 1'b0;
        tick();
        total++;
        if ({gval, gidx, bcnt} !== {1'b1, 2'd1, 4'd0}) begin
            bad++;
            $display("FAIL ar_regrant got=%b/%0d/%0d exp=1/1/0", gval, gidx, bcnt);
        end
    endtask

    task automatic test_random;
        bit m_val;
        int m_idx;
        int m_cnt;
        int m_q;
        int m_last;
        bit m_err;
        do_reset();
        m_val  = 1'b0;
        m_idx  = 0;
        m_cnt  = 0;
        m_q    = 1;
        m_last = NI - 1;
        m_err  = 1'b0;
        for (int c = 0; c < 500; c++) begin
            req = NI'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = '0;
            if ($urandom_range(0, 7) == 0) wt = ($urandom & 16'hFFFF);
            xfer = ($urandom_range(0, 3) != 0);
            eop  = ($urandom_range(0, 2) == 0);
            if (!m_val) begin
                if (xfer) m_err = 1'b1;
                if (req != 0) begin
                    m_idx = mpick(req, m_last);
                    m_val = 1'b1;
                    m_cnt = 0;
                    m_q   = int'(wt[WBITS*m_idx +: WBITS]);
                    if (m_q == 0) m_q = 1;
                end
            end else if (xfer && eop) begin
                if (m_cnt + 1 < m_q && req[m_idx]) begin
                    m_cnt = m_cnt + 1;
                end else if (req != 0) begin
                    m_last = m_idx;
                    m_idx  = mpick(req, m_last);
                    m_cnt  = 0;
                    m_q    = int'(wt[WBITS*m_idx +: WBITS]);
                    if (m_q == 0) m_q = 1;
                end else begin
                    m_val  = 1'b0;
                    m_last = m_idx;
                end
            end
            tick();
            total++;
            if (gval !== m_val || gidx !== NIB'(m_idx) || err !== m_err ||
                (m_val && bcnt !== WBITS'(m_cnt))) begin
                bad++;
                $display("FAIL rand cyc=%0d got v=%b i=%0d c=%0d e=%b exp v=%b i=%0d c=%0d e=%b",
                         c, gval, gidx, bcnt, err, m_val, m_idx, m_cnt, m_err);
            end
        end
        xfer = 1'b0;
        eop  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        wt    = '0;
        xfer  = 1'b0;
        eop   = 1'b0;
        test_reset();
        test_zero_bubble();
        test_weighted_seq();
        test_single_requester();
        test_mid_packet_drop();
        test_err_w0();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
